elastic_pipe_reg: RTL
=====================

Name: elastic_pipe_reg

Overview:
- Parametrised multi-stage pipeline register with valid/ready handshake, synchronous flush and occupancy count.
- Successor to the plain enable register for LX32 datapaths that cross stall boundaries: fetch-to-decode, decode-to-execute, LSU request paths.
- Collapses bubbles: a stage accepts new data whenever it is empty or its contents are moving downstream.

Parameters:
- WIDTH, 32, payload width in bits; must be >= 1.
- DEPTH, 2, number of register stages; must be >= 1, elaboration error otherwise.
- RESET_DATA, 1, 1 = data registers reset to '0; 0 = data registers have no reset (valid bits always reset).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all in-flight entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  block can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  valid of the last stage.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload of the last stage.
- count  out  CW  registered number of valid entries. CW = $clog2(DEPTH+1), or $clog2(DEPTH+2) when the optional feature is compiled in.

Behaviour:
- Reset (async):
  - all valid bits = 0 and count = 0.
  - out_valid = 0.
  - out_data = 0 when RESET_DATA = 1.
  - in_ready follows the reset state, so it is 1 during reset.
- Stage k in 0..DEPTH-1; stage DEPTH-1 drives out_*.
- adv[DEPTH-1] = !v[DEPTH-1] || out_ready. adv[k] = !v[k] || adv[k+1].
- in_ready = adv[0] && !flush. This path is combinational from out_ready.
- On adv[k]:
  - v[k] <= upstream valid.
  - d[k] <= upstream data, loaded only when upstream valid = 1, so bubbles do not toggle data.
- Fire events:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready.
- Latency: an accepted beat appears at out_valid DEPTH cycles later if never stalled. Throughput is 1 beat/cycle.
- Stall: out_ready = 0 holds out_data/out_valid stable. Upstream stages keep filling until all are valid, then in_ready = 0.
- Ordering: strictly FIFO; no beat is duplicated or dropped.
- Flush (sync, highest priority):
  - all v <= 0 and count <= 0.
  - in_ready = 0 that cycle, so no input is accepted.
  - out_fire is still reported to downstream if out_valid && out_ready.
  - data registers are not cleared.
- count:
  - count <= count + in_fire - out_fire; 0 on flush.
  - Invariant: count == popcount(v).
  - Never exceeds DEPTH (DEPTH+1 with skid).
- Simultaneous in_fire and out_fire with all stages full: legal, count unchanged.
- in_valid must not depend combinationally on in_ready. in_data is sampled only on in_fire.

Optional Feature:
- Macro: LX32_ELASTIC_PIPE_SKID_EN.
- Defined:
  - A one-entry skid buffer sits in front of stage 0, and in_ready = !skid_v && !flush, registered. This breaks the ready path.
  - If in_fire && !adv[0], the beat goes to the skid.
  - When skid_v = 1, stage 0 takes the skid entry before the next new input, preserving order.
  - Flush clears skid_v. The skid entry is counted in count.
  - Latency is unchanged when the skid is empty, and +0 when it drains in the same order.
- Undefined: no skid logic; in_ready is combinational as above.

Decomposition:
- Package lx32_pipe_pkg:
  - function pipe_cnt_w(depth, skid) returning CW.
  - localparam-free helper for popcount, used by assertions.
- Sub-module pipe_stage (WIDTH, RESET_DATA):
  - one valid/data register pair with adv and load-enable inputs.
  - instantiated DEPTH times in a generate loop.
- Skid logic stays inline under the macro.

Test Plan:
- Streaming: DEPTH=3, WIDTH=32, out_ready=1; push 0x1..0x8 back-to-back -> first out_valid 3 cycles after first in_fire, outputs 0x1..0x8 consecutive, count steady at 3.
- Backpressure: DEPTH=2; push 0xA,0xB,0xC with out_ready=0 -> in_ready drops after 2 accepts (3 with skid), count=2 (3), out_data holds 0xA; release -> 0xA,0xB,0xC in order.
- Bubble collapse: DEPTH=4; single beat 0x55, then out_ready=0 -> 0x55 advances to out stage; a second beat 0x66 is accepted every cycle until all 4 stages are full, count=4.
- Flush mid-stream: 3 valid entries with in_valid=1 and flush=1 -> in_ready=0 that cycle, next cycle out_valid=0, count=0; beat presented during flush is not accepted.
- Reset mid-operation: assert rst asynchronously with 2 entries valid -> out_valid=0 and count=0 immediately, before the next clock edge; out_data=0 (RESET_DATA=1).
- Random valid/ready scoreboard: 10k cycles, DEPTH=1..5, both macro settings -> in-order, no loss or duplication, count==popcount(v) every cycle.

Source files
------------

// File: rtl/lx32_pipe_pkg.sv
// lx32_pipe_pkg: shared build switch, count-width and popcount helpers for elastic_pipe_reg (macro LX32_ELASTIC_PIPE_SKID_EN)
package lx32_pipe_pkg;
`ifdef LX32_ELASTIC_PIPE_SKID_EN
  localparam int SKID_EN = 1;
`else
  localparam int SKID_EN = 0;
`endif
  function automatic int pipe_cnt_w(input int depth, input int skid);
    return $clog2(depth + 1 + skid);
  endfunction
  function automatic int popcount(input logic [63:0] x);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(x[i]);
    return n;
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid/data register pair; ports clk, rst, i_flush, i_adv, i_valid, i_data -> o_valid, o_data
module pipe_stage #(
  parameter int WIDTH      = 32,
  parameter bit RESET_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_adv,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic w_load;
  assign w_load = i_adv && i_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) o_valid <= 1'b0;
    else if (i_flush) o_valid <= 1'b0;
    else if (i_adv) o_valid <= i_valid;
  if (RESET_DATA) begin : g_rst
    always_ff @(posedge clk or posedge rst)
      if (rst) o_data <= '0;
      else if (w_load) o_data <= i_data;
  end else begin : g_nrst
    always_ff @(posedge clk)
      if (w_load) o_data <= i_data;
  end
endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH-stage valid/ready pipeline with flush and occupancy count; optional skid via LX32_ELASTIC_PIPE_SKID_EN; ports clk, rst, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data, count
module elastic_pipe_reg
  import lx32_pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2,
  parameter bit RESET_DATA = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [WIDTH-1:0]                        in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [WIDTH-1:0]                        out_data,
  output logic [pipe_cnt_w(DEPTH, SKID_EN)-1:0]   count
);
  localparam int CW = pipe_cnt_w(DEPTH, SKID_EN);
  if (DEPTH < 1 || WIDTH < 1) begin : g_bad_cfg
    $error("elastic_pipe_reg: DEPTH and WIDTH must be >= 1");
  end
  logic [DEPTH-1:0]            w_v;
  logic [DEPTH-1:0]            w_adv;
  logic [DEPTH-1:0][WIDTH-1:0] w_d;
  logic                        w_src_v;
  logic [WIDTH-1:0]            w_src_d;
  logic                        w_skid_v;
  logic                        w_in_fire;
  logic                        w_out_fire;
  assign w_in_fire  = in_valid && in_ready;
  assign out_valid  = w_v[DEPTH-1];
  assign out_data   = w_d[DEPTH-1];
  assign w_out_fire = out_valid && out_ready;
  // A stage moves when any stage at or after it is empty, or the output drains.
  for (genvar k = 0; k < DEPTH; k++) begin : g_adv
    assign w_adv[k] = out_ready || !(&w_v[DEPTH-1:k]);
  end
`ifdef LX32_ELASTIC_PIPE_SKID_EN
  logic             r_skid_v;
  logic [WIDTH-1:0] r_skid_d;
  // Ready depends only on registered skid state, cutting the out_ready path.
  assign in_ready = !r_skid_v && !flush;
  assign w_src_v  = r_skid_v || w_in_fire;
  assign w_src_d  = r_skid_v ? r_skid_d : in_data;
  assign w_skid_v = r_skid_v;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
    end else if (flush) begin
      r_skid_v <= 1'b0;
    end else if (r_skid_v) begin
      if (w_adv[0]) r_skid_v <= 1'b0;
    end else if (w_in_fire && !w_adv[0]) begin
      r_skid_v <= 1'b1;
      r_skid_d <= in_data;
    end
`else
  assign in_ready = w_adv[0] && !flush;
  assign w_src_v  = w_in_fire;
  assign w_src_d  = in_data;
  assign w_skid_v = 1'b0;
`endif
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      pipe_stage #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_stage (
        .clk(clk), .rst(rst), .i_flush(flush), .i_adv(w_adv[k]),
        .i_valid(w_src_v), .i_data(w_src_d), .o_valid(w_v[k]), .o_data(w_d[k])
      );
    end else begin : g_body
      pipe_stage #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_stage (
        .clk(clk), .rst(rst), .i_flush(flush), .i_adv(w_adv[k]),
        .i_valid(w_v[k-1]), .i_data(w_d[k-1]), .o_valid(w_v[k]), .o_data(w_d[k])
      );
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (flush) count <= '0;
    else count <= count + CW'(w_in_fire) - CW'(w_out_fire);
  a_count_matches_valid: assert property (@(posedge clk) disable iff (rst)
    int'(count) == popcount(64'(w_v)) + int'(w_skid_v));
endmodule
